// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and the decoder. It presents one
// instruction/PC pair per cycle through a registered output stage.
`ifndef IDWidth
`define IDWidth 32
`endif
`ifndef AddressWidth
`define AddressWidth 32
`endif

module inst_queue #(
  parameter int QueueSize = 16,
  parameter int PtrWidth  = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     if_instqueue_en_in,
  input  logic [`IDWidth-1:0]      if_instqueue_inst_in,
  input  logic [`AddressWidth-1:0] if_instqueue_pc_in,
  output logic                     instqueue_if_full_out,
  output logic                     instqueue_decoder_en_out,
  output logic [`IDWidth-1:0]      instqueue_decoder_inst_out,
  output logic [`AddressWidth-1:0] instqueue_decoder_pc_out,
  input  logic                     decoder_instqueue_rst_in,
  input  logic                     rob_instqueue_rst_in,
  input  logic                     dispatcher_instqueue_stall_in
);

  localparam logic [PtrWidth:0]   FullCount = (PtrWidth + 1)'(QueueSize);
  localparam logic [PtrWidth:0]   CountOne  = (PtrWidth + 1)'(1);
  localparam logic [PtrWidth-1:0] PtrOne    = PtrWidth'(1);

  logic [`IDWidth-1:0]      inst_mem [QueueSize];
  logic [`AddressWidth-1:0] pc_mem   [QueueSize];

  logic [PtrWidth-1:0] head;
  logic [PtrWidth-1:0] tail;
  logic [PtrWidth:0]   count;
  logic                flush;
  logic                push;
  logic                pop;

  assign flush                 = decoder_instqueue_rst_in | rob_instqueue_rst_in;
  assign instqueue_if_full_out = (count == FullCount);
  // Full is judged on the current count, so a pop never frees a slot for a same-cycle push.
  assign push = if_instqueue_en_in && !instqueue_if_full_out;
  assign pop  = (count != '0) && !dispatcher_instqueue_stall_in;

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !flush && push) begin
      inst_mem[tail] <= if_instqueue_inst_in;
      pc_mem[tail]   <= if_instqueue_pc_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head                       <= '0;
      tail                       <= '0;
      count                      <= '0;
      instqueue_decoder_en_out   <= 1'b0;
      instqueue_decoder_inst_out <= '0;
      instqueue_decoder_pc_out   <= '0;
    end else if (!rdy_in) begin
      instqueue_decoder_en_out <= 1'b0;
    end else if (flush) begin
      head                     <= '0;
      tail                     <= '0;
      count                    <= '0;
      instqueue_decoder_en_out <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + PtrOne;
      end
      if (pop) begin
        instqueue_decoder_en_out   <= 1'b1;
        instqueue_decoder_inst_out <= inst_mem[head];
        instqueue_decoder_pc_out   <= pc_mem[head];
        head                       <= head + PtrOne;
      end else begin
        instqueue_decoder_en_out <= 1'b0;
      end
      if (push && !pop) begin
        count <= count + CountOne;
      end else if (!push && pop) begin
        count <= count - CountOne;
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Randomised scoreboard bench for inst_queue. A queue-based reference model
// predicts each delivery, and a negedge monitor checks what the DUT presents.
`ifndef IDWidth
`define IDWidth 32
`endif
`ifndef AddressWidth
`define AddressWidth 32
`endif

module tb_inst_queue;

  localparam int QS = 16;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        if_instqueue_en_in = 1'b0;
  logic [31:0] if_instqueue_inst_in = '0;
  logic [31:0] if_instqueue_pc_in = '0;
  logic        instqueue_if_full_out;
  logic        instqueue_decoder_en_out;
  logic [31:0] instqueue_decoder_inst_out;
  logic [31:0] instqueue_decoder_pc_out;
  logic        decoder_instqueue_rst_in = 1'b0;
  logic        rob_instqueue_rst_in = 1'b0;
  logic        dispatcher_instqueue_stall_in = 1'b0;

  logic [63:0] model_q[$];
  logic [63:0] exp_q[$];
  logic        exp_en = 1'b0;
  logic [63:0] last_item = '0;
  bit          model_valid = 1'b0;
  int          checks = 0;
  int          failures = 0;

  inst_queue #(.QueueSize(QS), .PtrWidth(4)) dut (
    .clk_in                       (clk_in),
    .rst_in                       (rst_in),
    .rdy_in                       (rdy_in),
    .if_instqueue_en_in           (if_instqueue_en_in),
    .if_instqueue_inst_in         (if_instqueue_inst_in),
    .if_instqueue_pc_in           (if_instqueue_pc_in),
    .instqueue_if_full_out        (instqueue_if_full_out),
    .instqueue_decoder_en_out     (instqueue_decoder_en_out),
    .instqueue_decoder_inst_out   (instqueue_decoder_inst_out),
    .instqueue_decoder_pc_out     (instqueue_decoder_pc_out),
    .decoder_instqueue_rst_in     (decoder_instqueue_rst_in),
    .rob_instqueue_rst_in         (rob_instqueue_rst_in),
    .dispatcher_instqueue_stall_in(dispatcher_instqueue_stall_in)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: the queue contents as a plain FIFO, applying the priority order.
  always @(posedge clk_in) begin : reference_model
    bit do_pop;
    bit full_now;
    if (rst_in) begin
      model_q.delete();
      exp_q.delete();
      exp_en = 1'b0;
      last_item = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (!rdy_in) begin
        exp_en = 1'b0;
      end else if (decoder_instqueue_rst_in || rob_instqueue_rst_in) begin
        model_q.delete();
        exp_en = 1'b0;
      end else begin
        full_now = (model_q.size() == QS);
        do_pop = (model_q.size() != 0) && !dispatcher_instqueue_stall_in;
        exp_en = do_pop;
        if (do_pop) begin
          last_item = model_q.pop_front();
          exp_q.push_back(last_item);
        end
        if (if_instqueue_en_in && !full_now)
          model_q.push_back({if_instqueue_inst_in, if_instqueue_pc_in});
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk_in) begin : monitor
    logic [63:0] item;
    if (model_valid) begin
      checkOutput("en_out", 64'(instqueue_decoder_en_out), 64'(exp_en));
      if (instqueue_decoder_en_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_delivery actual pc=%h expected none at %0t",
                   instqueue_decoder_pc_out, $time);
        end else begin
          item = exp_q.pop_front();
          checkOutput("delivered", {instqueue_decoder_inst_out, instqueue_decoder_pc_out}, item);
        end
      end else begin
        checkOutput("held_output", {instqueue_decoder_inst_out, instqueue_decoder_pc_out},
                    last_item);
      end
      checkOutput("full_out", 64'(instqueue_if_full_out), 64'(model_q.size() == QS));
      checkOutput("count", 64'(dut.count), 64'(model_q.size()));
    end
  end

  task automatic applyStimulus(input logic en, input logic [31:0] inst, input logic [31:0] pc,
                               input logic stall, input logic rdy, input logic dflush,
                               input logic rflush, input logic rst);
    if_instqueue_en_in            = en;
    if_instqueue_inst_in          = inst;
    if_instqueue_pc_in            = pc;
    dispatcher_instqueue_stall_in = stall;
    rdy_in                        = rdy;
    decoder_instqueue_rst_in      = dflush;
    rob_instqueue_rst_in          = rflush;
    rst_in                        = rst;
    @(negedge clk_in);
  endtask

  task automatic idle(input int n, input logic stall);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, stall, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pushOne(input logic [31:0] pc, input logic stall);
    applyStimulus(1'b1, $urandom, pc, stall, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    $display("[TB] three back-to-back pushes");
    applyStimulus(1'b1, 32'h00000013, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00100093, 32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00200113, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);

    $display("[TB] fill to full under stall, overflow push ignored");
    for (int i = 0; i < QS; i++) pushOne(32'(i * 4), 1'b1);
    pushOne(32'h40, 1'b1);
    idle(1, 1'b1);
    idle(QS + 3, 1'b0);

    $display("[TB] wrap-around with stall bubbles");
    for (int i = 0; i < 20; i++) pushOne(32'h1000 + 32'(i * 4), (i % 3) == 1);
    idle(QS + 3, 1'b0);

    $display("[TB] decoder flush then rob flush");
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) pushOne(32'h2000 + 32'(i * 4), 1'b1);
      applyStimulus(1'b1, $urandom, 32'h100, 1'b0, 1'b1, k == 0, k == 1, 1'b0);
      pushOne(32'h200, 1'b0);
      idle(4, 1'b0);
    end

    $display("[TB] rdy low with pushes pending");
    for (int i = 0; i < 4; i++) pushOne(32'h3000 + 32'(i * 4), 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, $urandom, 32'h3100 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8, 1'b0);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 7; i++) pushOne(32'h4000 + 32'(i * 4), 1'b1);
    applyStimulus(1'b1, $urandom, 32'h4100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 99) == 0);

    idle(QS + 4, 1'b0);
    #1;
    checkOutput("drained_scoreboard", 64'(exp_q.size()), 64'd0);
    checkOutput("drained_model", 64'(model_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Circular FIFO between instruction fetch and the decoder.
- Buffers fetched instruction/PC pairs, presents one pair per cycle to the decoder through a registered output stage, and applies backpressure to fetch when full.
- Flushed by the decoder on a JAL redirect and by the ROB on a misprediction or exception.
- Producer end of the instqueue→decoder interface.

Parameters:
- QueueSize, 16, number of entries; power of two, at least 2.
- PtrWidth, 4, log2(QueueSize).

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; low freezes the block
- if_instqueue_en_in  input  1  push request from fetch
- if_instqueue_inst_in  input  `IDWidth  fetched instruction
- if_instqueue_pc_in  input  `AddressWidth  PC of fetched instruction
- instqueue_if_full_out  output  1  queue full; fetch must not push
- instqueue_decoder_en_out  output  1  valid instruction presented to decoder this cycle
- instqueue_decoder_inst_out  output  `IDWidth  instruction to decoder
- instqueue_decoder_pc_out  output  `AddressWidth  PC to decoder
- decoder_instqueue_rst_in  input  1  flush from decoder (JAL redirect)
- rob_instqueue_rst_in  input  1  flush from ROB (mispredict/exception)
- dispatcher_instqueue_stall_in  input  1  downstream RS/LSB/ROB cannot accept

Behaviour:
- Interface: one clock `clk_in`; `rst_in` is synchronous and active-high.
- State:
  - inst/pc storage arrays of QueueSize entries.
  - head and tail pointers, PtrWidth bits, wrap modulo QueueSize.
  - count, PtrWidth+1 bits, range 0..QueueSize.
- Priority per rising edge: rst_in > !rdy_in > flush > normal.
- Reset:
  - head=tail=count=0.
  - en_out=0, inst_out=0, pc_out=0.
  - full_out=0.
  - Storage contents don't-care.
- rdy_in low:
  - Pointers, count and storage hold.
  - en_out<=0 so no instruction is delivered twice; inst_out/pc_out hold.
- Flush (decoder_instqueue_rst_in | rob_instqueue_rst_in):
  - head=tail=count=0; en_out<=0.
  - A push in the same cycle is discarded; a pop in the same cycle does not occur.
  - The instruction currently on the outputs (e.g. the JAL causing the flush) is considered consumed this cycle.
- Push: when if_instqueue_en_in && !full.
  - mem[tail] <= {inst, pc}; tail <= tail+1 (wraps QueueSize-1→0).
  - A push while full is ignored, with no corruption.
- Pop: when count!=0 && !dispatcher_instqueue_stall_in.
  - en_out<=1; inst_out<=mem[head]; pc_out<=pc mem[head]; head<=head+1 (wraps).
  - Otherwise en_out<=0, and inst_out/pc_out hold.
- count update: count += push - pop. Simultaneous push and pop leaves count unchanged.
- Entry availability: an entry written at edge N is poppable at edge N+1 earliest.
  - No empty-queue bypass.
  - Latency: push sampled at edge N → en_out high in the cycle after edge N+1.
- full_out:
  - Combinational, = (count == QueueSize).
  - Full is evaluated on the current count, so a simultaneous pop does not admit a push into a full queue.
- en_out is a single-cycle pulse per popped entry. Each entry is delivered exactly once, in FIFO order.
- Stall: while stall is high, no pop and en_out=0; entries are retained.
- Throughput: one push and one pop per cycle sustained.

Test Plan:
- Reset then push 3 instrs (0x00000013@0x0, 0x00100093@0x4, 0x00200113@0x8) on consecutive edges with no stall → en_out pulses on 3 consecutive cycles, first pulse the cycle after the 2nd edge; outputs match in order; count returns to 0.
- Stall high, push 16 entries (pc 0x00..0x3C) → full_out=1 after the 16th; a 17th push (pc 0x40) is ignored. Release stall → 16 pops with pc 0x00..0x3C in order; pc 0x40 never appears; full_out drops after the first pop.
- Wrap-around: push/pop 20 entries with 1-cycle stall bubbles → pointers wrap, order preserved, no loss or duplicate.
- Flush: 5 entries queued; pulse decoder_instqueue_rst_in together with a push (pc 0x100) → next cycle en_out=0, count=0, full_out=0; a subsequent push pc 0x200 is the next delivered entry. Repeat the same check with rob_instqueue_rst_in.
- rdy_in low for 3 cycles while 4 entries are queued and pushes are asserted → no en_out, no state change; on rdy_in high delivery resumes in order with no duplicate.
- rst_in mid-operation with 7 entries queued → all outputs return to reset values next cycle; old entries are never delivered.
